// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// FSM state type, wait-state counter width and the load-extension helper.
package dmem_pkg;

    localparam int CNT_W = 3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;   // 2'b11 is handled as a word too

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Pick the addressed byte/half out of a little-endian word and extend it.
    // Halfwords only look at lane[1], so an odd half address reads the
    // containing aligned half.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: res = {{24{sext & b[7]}}, b};
            SIZE_HALF: res = {{16{sext & h[15]}}, h};
            default:   res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port word array with per-byte write enables and a registered
// (read-first) output. Holds 2^ADDR_W 32-bit words.
module dmem_bram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q;

    // Byte-masked write and synchronous read of the addressed word.
    // NOTE: the array has no reset; clearing every word would force flops
    // instead of a RAM macro, and software never relies on initial contents.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory controller: IDLE/WAIT/RESP handshake with
// WAIT_CYCLES wait states, byte/half/word lane steering and load extension.
// Optional feature: define DMEM_ALIGN_CHECK_EN to trap misaligned accesses
// (adel/ades pulse, badaddr capture, array untouched).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badaddr
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Access captured at accept time.
    logic              we_q, sext_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;

    // Access as seen on the edge that touches the array: straight from the
    // inputs when leaving IDLE (zero wait states), otherwise the captured copy.
    logic              acc_we;
    logic [1:0]        acc_size;
    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata;

    logic              accept;
    logic              misalign;
    logic              mem_en;
    logic [3:0]        lane_be;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Upper address bits fall outside the array and simply wrap.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign accept = (state_q == IDLE) && req;

    // Select the live or captured access fields.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = we;
            acc_size  = size;
            acc_addr  = addr[ADDR_W+1:0];
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((acc_size == SIZE_HALF) && acc_addr[0]) ||
                      (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Next-state and wait-counter logic.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (misalign || (WAIT_CYCLES == 0)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields when it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            sext_q  <= sext;
            err_q   <= misalign;
            size_q  <= size;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
        end
    end

    // Store lane steering: replicate the right-aligned data and enable lanes.
    always_comb begin
        lane_be   = 4'b1111;
        mem_wdata = acc_wdata;
        case (acc_size)
            SIZE_BYTE: begin
                lane_be   = 4'b0001 << acc_addr[1:0];
                mem_wdata = {4{acc_wdata[7:0]}};
            end
            SIZE_HALF: begin
                lane_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_be   = 4'b1111;
                mem_wdata = acc_wdata;
            end
        endcase
    end

    // The array is touched only on the edge entering RESP; reset on that
    // edge cancels the access, and a trapped access never reaches it.
    assign mem_en = !reset && (state_q != RESP) && (state_d == RESP) && !misalign;
    assign mem_we = acc_we ? lane_be : 4'b0000;

    dmem_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (acc_addr[ADDR_W+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign ready = (state_q == RESP);
    assign stall = req & ~ready;
    assign rdata = (ready && !we_q && !err_q) ?
                   load_extend(mem_rdata, size_q, addr_q[1:0], sext_q) : '0;

`ifdef DMEM_ALIGN_CHECK_EN
    logic [31:0] badaddr_q;

    // Remember the full address of the most recent trapped access.
    always_ff @(posedge clk) begin
        if (reset) begin
            badaddr_q <= '0;
        end else if (accept && misalign) begin
            badaddr_q <= addr;
        end
    end

    assign adel    = ready & err_q & ~we_q;
    assign ades    = ready & err_q & we_q;
    assign badaddr = badaddr_q;
`else
    assign adel    = 1'b0;
    assign ades    = 1'b0;
    assign badaddr = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: dut0 runs with zero wait states, dut1 with
// one. Drivers push expected completions; a negedge monitor pops on ready.
module tb_dmem_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic [31:0] badaddr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst     [2];
    logic        req     [2];
    logic        we      [2];
    logic [1:0]  size    [2];
    logic        sext    [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic        stall   [2];
    logic        adel    [2];
    logic        ades    [2];
    logic [31:0] badaddr [2];

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] bad1;
    logic        st [5];

    dmem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]),
        .sext(sext[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .ready(ready[0]), .stall(stall[0]), .adel(adel[0]), .ades(ades[0]),
        .badaddr(badaddr[0])
    );

    dmem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]),
        .sext(sext[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .ready(ready[1]), .stall(stall[1]), .adel(adel[1]), .ades(ades[1]),
        .badaddr(badaddr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation of one DUT and compare its completion.
    task automatic mon(input int d);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            check($sformatf("dut%0d_unexpected_ready", d), {31'b0, ready[d]}, 32'd0);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d_ready_cycle", d), 32'(cyc), 32'(e.cyc));
            check($sformatf("dut%0d_rdata@%0d", d, e.cyc), rdata[d], e.rdata);
            check($sformatf("dut%0d_adel@%0d", d, e.cyc), {31'b0, adel[d]}, {31'b0, e.adel});
            check($sformatf("dut%0d_ades@%0d", d, e.cyc), {31'b0, ades[d]}, {31'b0, e.ades});
            check($sformatf("dut%0d_badaddr@%0d", d, e.cyc), badaddr[d], e.badaddr);
        end
    endtask

    always @(negedge clk) begin
        if (ready[0] === 1'b1) mon(0);
        if (ready[1] === 1'b1) mon(1);
    end

    // Issue one access, record its expected completion, hold req until ready.
    // chain=1 means the caller is already just past a rising edge.
    task automatic access(input int d, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input logic [31:0] erd, input logic eadel,
                          input logic eades, input logic [31:0] ebad, input bit chain);
        exp_t e;
        bit   seen;
        if (!chain) begin
            @(posedge clk);
            #1;
        end
        req[d] = 1'b1; we[d] = w; size[d] = sz; sext[d] = sx; addr[d] = a; wdata[d] = wd;
        e.rdata = erd; e.adel = eadel; e.ades = eades; e.badaddr = ebad; e.cyc = cyc + lat;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (ready[d] === 1'b1) seen = 1'b1;
        end
        if (!seen) check($sformatf("dut%0d_ready_timeout", d), {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = SZ_B;
            sext[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_rst_ready", d),   {31'b0, ready[d]}, 32'd0);
            check($sformatf("dut%0d_rst_rdata", d),   rdata[d], 32'd0);
            check($sformatf("dut%0d_rst_adel", d),    {31'b0, adel[d]}, 32'd0);
            check($sformatf("dut%0d_rst_ades", d),    {31'b0, ades[d]}, 32'd0);
            check($sformatf("dut%0d_rst_badaddr", d), badaddr[d], 32'd0);
            check($sformatf("dut%0d_rst_stall", d),   {31'b0, stall[d]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // One wait state: word store/load, byte and half lanes.
        bad1 = 32'h0;
        access(1, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0,        0, 0, bad1, 0);
        access(1, 0, SZ_W, 0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 0, 0, bad1, 0);
        access(1, 1, SZ_B, 0, 32'h11, 32'h0000007F, 2, 32'h0,        0, 0, bad1, 0);
        access(1, 0, SZ_B, 1, 32'h11, 32'h0,        2, 32'h0000007F, 0, 0, bad1, 0);
        access(1, 0, SZ_B, 0, 32'h13, 32'h0,        2, 32'h000000DE, 0, 0, bad1, 0);
        access(1, 0, SZ_H, 1, 32'h12, 32'h0,        2, 32'hFFFFDEAD, 0, 0, bad1, 0);
        access(1, 0, SZ_W, 0, 32'h10, 32'h0,        2, 32'hDEAD7FEF, 0, 0, bad1, 0);
        access(1, 1, SZ_W, 0, 32'h30, 32'h0,        2, 32'h0,        0, 0, bad1, 0);
        access(1, 1, SZ_H, 0, 32'h32, 32'h1234BEEF, 2, 32'h0,        0, 0, bad1, 0);
        access(1, 0, SZ_W, 0, 32'h30, 32'h0,        2, 32'hBEEF0000, 0, 0, bad1, 0);
        access(1, 0, SZ_H, 0, 32'h32, 32'h0,        2, 32'h0000BEEF, 0, 0, bad1, 0);
        access(1, 0, SZ_B, 1, 32'h33, 32'h0,        2, 32'hFFFFFFBE, 0, 0, bad1, 0);
        access(1, 0, SZ_H, 1, 32'h30, 32'h0,        2, 32'h00000000, 0, 0, bad1, 0);
        access(1, 0, 2'b11, 0, 32'h30, 32'h0,       2, 32'hBEEF0000, 0, 0, bad1, 0);
        access(1, 1, SZ_B, 0, 32'h30, 32'h00000080, 2, 32'h0,        0, 0, bad1, 0);
        access(1, 0, SZ_B, 1, 32'h30, 32'h0,        2, 32'hFFFFFF80, 0, 0, bad1, 0);

        // Misaligned accesses: trapped with the check, aligned-down without.
        access(1, 1, SZ_W, 0, 32'h20, 32'hCAFEF00D, 2, 32'h0, 0, 0, bad1, 0);
        bad1 = ALIGN ? 32'h22 : 32'h0;
        access(1, 1, SZ_W, 0, 32'h22, 32'h11111111, ALIGN ? 1 : 2, 32'h0, 0, ALIGN, bad1, 0);
        access(1, 0, SZ_W, 0, 32'h20, 32'h0, 2,
               ALIGN ? 32'hCAFEF00D : 32'h11111111, 0, 0, bad1, 0);
        bad1 = ALIGN ? 32'h21 : 32'h0;
        access(1, 0, SZ_W, 0, 32'h21, 32'h0, ALIGN ? 1 : 2,
               ALIGN ? 32'h0 : 32'h11111111, ALIGN, 0, bad1, 0);
        bad1 = ALIGN ? 32'h13 : 32'h0;
        access(1, 0, SZ_H, 0, 32'h13, 32'h0, ALIGN ? 1 : 2,
               ALIGN ? 32'h0 : 32'h0000DEAD, ALIGN, 0, bad1, 0);

        // Reset in the cycle before the write edge aborts the store; the
        // request still high during reset must not be accepted either.
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_W; sext[1] = 1'b0;
        addr[1] = 32'h10; wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("dut1_wait_ready", {31'b0, ready[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        req[1] = 1'b0;
        bad1 = 32'h0;
        @(negedge clk);
        check("dut1_abort_ready",   {31'b0, ready[1]}, 32'd0);
        check("dut1_abort_rdata",   rdata[1], 32'd0);
        check("dut1_abort_badaddr", badaddr[1], 32'd0);
        access(1, 0, SZ_W, 0, 32'h10, 32'h0, 2, 32'hDEAD7FEF, 0, 0, bad1, 0);

        // Address wrap modulo 4 KiB for ADDR_W = 10.
        access(1, 1, SZ_W, 0, 32'h1000, 32'h00000055, 2, 32'h0,        0, 0, bad1, 0);
        access(1, 0, SZ_W, 0, 32'h0,    32'h0,        2, 32'h00000055, 0, 0, bad1, 0);
        access(1, 0, SZ_W, 0, 32'h1010, 32'h0,        2, 32'hDEAD7FEF, 0, 0, bad1, 0);

        // Zero wait states: back-to-back loads with req held.
        access(0, 1, SZ_W, 0, 32'h10, 32'hA5A5A5A5, 1, 32'h0, 0, 0, 32'h0, 0);
        access(0, 1, SZ_W, 0, 32'h14, 32'h5A5A5A5A, 1, 32'h0, 0, 0, 32'h0, 0);
        fork
            begin
                access(0, 0, SZ_W, 0, 32'h10, 32'h0, 1, 32'hA5A5A5A5, 0, 0, 32'h0, 0);
                access(0, 0, SZ_W, 0, 32'h14, 32'h0, 1, 32'h5A5A5A5A, 0, 0, 32'h0, 1);
            end
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    st[i] = stall[0];
                end
            end
        join
        check("dut0_stall_c0", {31'b0, st[0]}, 32'd1);
        check("dut0_stall_c1", {31'b0, st[1]}, 32'd0);
        check("dut0_stall_c2", {31'b0, st[2]}, 32'd1);
        check("dut0_stall_c3", {31'b0, st[3]}, 32'd0);
        check("dut0_stall_c4", {31'b0, st[4]}, 32'd0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
